// File: rtl/mem_bist_ctrl_pkg.sv
// Shared types and defaults for the memory BIST controller: FSM states, march phases
// and the phase-sequencing helpers used by the controller and the pattern generator.
package mem_bist_ctrl_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 9;
    localparam int unsigned DEF_WIDTH      = 16;
    localparam int unsigned DEF_DEPTH      = 512;
    localparam int unsigned DEF_TIMEOUT    = 64;
    localparam logic [15:0] DEF_SEED       = 16'hA5A5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_GAP,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        PH_W0,
        PH_R0,
        PH_W1,
        PH_R1
    } phase_e;

    function automatic logic isWritePhase(phase_e p);
        return (p == PH_W0) || (p == PH_W1);
    endfunction

    // The second half of the march works on the complemented pattern.
    function automatic logic isInvertedPhase(phase_e p);
        return (p == PH_W1) || (p == PH_R1);
    endfunction

    function automatic phase_e nextPhase(phase_e p);
        phase_e n;
        case (p)
            PH_W0:   n = PH_R0;
            PH_R0:   n = PH_W1;
            PH_W1:   n = PH_R1;
            default: n = PH_R1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_bist_ctrl_pattern.sv
// March data generator: address xor seed, complemented in the W1/R1 phases.
// The same value serves as write data and as the expected read data.
module mem_bist_pattern
    import mem_bist_ctrl_pkg::*;
#(
    parameter int unsigned      ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned      WIDTH      = DEF_WIDTH,
    parameter logic [WIDTH-1:0] SEED       = DEF_SEED
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [1:0]            phase_i,
    output logic [WIDTH-1:0]      data_o
);

    logic [WIDTH-1:0] baseData;

    always_comb begin
        baseData = WIDTH'(addr_i) ^ SEED;
        data_o   = isInvertedPhase(phase_e'(phase_i)) ? ~baseData : baseData;
    end

endmodule

// File: rtl/mem_bist_ctrl.sv
// Memory BIST master: marches W0/R0/W1/R1 over the array through a valid/ready port
// and reports pass/fail, a saturating error count, the first failing address and timeout.
module mem_bist_ctrl
    import mem_bist_ctrl_pkg::*;
#(
    parameter int unsigned      ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned      WIDTH      = DEF_WIDTH,
    parameter int unsigned      DEPTH      = DEF_DEPTH,
    parameter logic [WIDTH-1:0] SEED       = DEF_SEED,
    parameter int unsigned      TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  timeout_o,
    output logic [15:0]           err_cnt_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  wr_rd_o,
    output logic [WIDTH-1:0]      wdata_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    input  logic [WIDTH-1:0]      rdata_i
);

    localparam int unsigned           TIMER_W     = $clog2(TIMEOUT + 1);
    localparam logic [TIMER_W-1:0]    TIMER_LIMIT = TIMER_W'(TIMEOUT);
    localparam logic [TIMER_W-1:0]    TIMER_ONE   = TIMER_W'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE    = ADDR_WIDTH'(1);
    localparam logic [15:0]           ERR_ONE     = 16'd1;

    state_e                state_q, state_d;
    phase_e                phase_q, phase_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [15:0]           errCnt_q, errCnt_d;
    logic [ADDR_WIDTH-1:0] firstErr_q, firstErr_d;
    logic                  timeout_q, timeout_d;

    logic [WIDTH-1:0]      expData;
    logic [TIMER_W-1:0]    timerNext;
    logic                  writePhase;
    logic                  mismatch;
    logic                  accessActive;

    mem_bist_pattern #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIDTH      (WIDTH),
        .SEED       (SEED)
    ) u_pattern (
        .addr_i  (addr_q),
        .phase_i (phase_q),
        .data_o  (expData)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            phase_q    <= PH_W0;
            addr_q     <= '0;
            timer_q    <= '0;
            errCnt_q   <= '0;
            firstErr_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            addr_q     <= addr_d;
            timer_q    <= timer_d;
            errCnt_q   <= errCnt_d;
            firstErr_q <= firstErr_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        addr_d     = addr_q;
        timer_d    = timer_q;
        errCnt_d   = errCnt_q;
        firstErr_d = firstErr_q;
        timeout_d  = timeout_q;
        timerNext  = timer_q + TIMER_ONE;
        writePhase = isWritePhase(phase_q);
        mismatch   = !writePhase && (rdata_i != expData);

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d    = ST_REQ;
                    phase_d    = PH_W0;
                    addr_d     = '0;
                    timer_d    = '0;
                    errCnt_d   = '0;
                    firstErr_d = '0;
                    timeout_d  = 1'b0;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                timer_d = timerNext;
                if (ready_i) begin
                    state_d = ST_GAP;
                    // A non-zero count already means the first failing address is latched.
                    if (mismatch) begin
                        if (errCnt_q != '1) begin
                            errCnt_d = errCnt_q + ERR_ONE;
                        end
                        if (errCnt_q == '0) begin
                            firstErr_d = addr_q;
                        end
                    end
                end else if (timerNext == TIMER_LIMIT) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
            end
            ST_GAP: begin
                timer_d = timerNext;
                if (!ready_i) begin
                    timer_d = '0;
                    state_d = ST_REQ;
                    if (addr_q == LAST_ADDR) begin
                        addr_d = '0;
                        if (phase_q == PH_R1) begin
                            state_d = ST_DONE;
                        end else begin
                            phase_d = nextPhase(phase_q);
                        end
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                end else if (timerNext == TIMER_LIMIT) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request signals are forced to zero outside REQ/WAIT so they can only move while valid is low.
    always_comb begin
        accessActive     = (state_q == ST_REQ) || (state_q == ST_WAIT);
        valid_o          = accessActive;
        wr_rd_o          = accessActive && isWritePhase(phase_q);
        wdata_o          = (accessActive && isWritePhase(phase_q)) ? expData : '0;
        addr_o           = addr_q;
        busy_o           = accessActive || (state_q == ST_GAP);
        done_o           = (state_q == ST_DONE);
        pass_o           = (state_q == ST_DONE) && (errCnt_q == '0) && !timeout_q;
        timeout_o        = timeout_q;
        err_cnt_o        = errCnt_q;
        first_err_addr_o = firstErr_q;
    end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: a behavioural valid/ready memory with injectable faults and
// random latency, plus a march-level reference model of the expected BIST results.
module tb_mem_bist_ctrl;

    localparam int unsigned ADDR_WIDTH = 9;
    localparam int unsigned WIDTH      = 16;
    localparam int unsigned DEPTH      = 16;
    localparam logic [15:0] SEED       = 16'hA5A5;
    localparam int unsigned TIMEOUT    = 8;

    typedef enum int {MEM_GOOD, MEM_STUCK, MEM_ZERO, MEM_NOREADY} memMode_e;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  busy, done, pass, tmo;
    logic [15:0]           errCnt;
    logic [ADDR_WIDTH-1:0] firstErr;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wrRd;
    logic [WIDTH-1:0]      wdata;
    logic                  valid;
    logic                  ready = 1'b0;
    logic [WIDTH-1:0]      rdata = '0;

    memMode_e         memMode = MEM_GOOD;
    int               faultAddr, faultBit;
    logic             faultVal;
    logic [WIDTH-1:0] memArray [DEPTH];

    bit               pending = 1'b0;
    bit               readyHeld = 1'b0;
    int               lat = 0;
    int               handshakes = 0;
    int               validRises = 0;
    int               protoErrs = 0;
    logic             prevValid = 1'b0;
    logic [ADDR_WIDTH-1:0] prevAddr = '0;
    logic             prevWr = 1'b0;
    logic [WIDTH-1:0] prevWdata = '0;

    int vectors = 0;
    int miscompares = 0;
    int cycles;

    always #5 clk = ~clk;

    mem_bist_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .SEED       (SEED),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .busy_o           (busy),
        .done_o           (done),
        .pass_o           (pass),
        .timeout_o        (tmo),
        .err_cnt_o        (errCnt),
        .first_err_addr_o (firstErr),
        .addr_o           (addr),
        .wr_rd_o          (wrRd),
        .wdata_o          (wdata),
        .valid_o          (valid),
        .ready_i          (ready),
        .rdata_i          (rdata)
    );

    // Faults act on the read path only, so the array always holds what was written.
    function automatic logic [WIDTH-1:0] readCell(input int a);
        logic [WIDTH-1:0] d;
        d = memArray[a];
        if (memMode == MEM_ZERO) d = '0;
        else if (memMode == MEM_STUCK && a == faultAddr) d[faultBit] = faultVal;
        return d;
    endfunction

    // Memory model, evaluated on the falling edge so ready/rdata are stable at the rising edge.
    always @(negedge clk) begin
        if (rst) begin
            ready = 1'b0;
            pending = 1'b0;
            readyHeld = 1'b0;
        end else if (valid) begin
            if (!ready) begin
                if (!pending) begin
                    pending = 1'b1;
                    lat = int'($urandom_range(3, 1));
                end else begin
                    lat = lat - 1;
                    if (lat == 0 && memMode != MEM_NOREADY) begin
                        ready = 1'b1;
                        handshakes = handshakes + 1;
                        if (wrRd) memArray[int'(addr) % DEPTH] = wdata;
                        else rdata = readCell(int'(addr) % DEPTH);
                    end
                end
            end
        end else begin
            pending = 1'b0;
            if (ready && !readyHeld && $urandom_range(1, 0) == 1) begin
                readyHeld = 1'b1;
            end else begin
                ready = 1'b0;
                readyHeld = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (valid && !prevValid) validRises = validRises + 1;
        if (valid && prevValid && (addr !== prevAddr || wrRd !== prevWr || wdata !== prevWdata))
            protoErrs = protoErrs + 1;
        if (valid && !wrRd && wdata !== '0) protoErrs = protoErrs + 1;
        if (valid && int'(addr) >= DEPTH) protoErrs = protoErrs + 1;
        prevValid = valid;
        prevAddr  = addr;
        prevWr    = wrRd;
        prevWdata = wdata;
    end

    // Expected results of a full march, derived directly from the fault rules.
    function automatic void refModel(output int expErr, output int expFirst, output logic expTimeout);
        logic [WIDTH-1:0] good, seen;
        expErr = 0;
        expFirst = 0;
        expTimeout = (memMode == MEM_NOREADY);
        if (expTimeout) return;
        for (int ph = 0; ph < 2; ph++) begin
            for (int a = 0; a < DEPTH; a++) begin
                good = 16'(a) ^ SEED;
                if (ph == 1) good = ~good;
                seen = good;
                if (memMode == MEM_ZERO) seen = '0;
                else if (memMode == MEM_STUCK && a == faultAddr) seen[faultBit] = faultVal;
                if (seen != good) begin
                    if (expErr == 0) expFirst = a;
                    expErr = (expErr < 16'hFFFF) ? expErr + 1 : expErr;
                end
            end
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors = vectors + 1;
        assert (observed === expected)
        else begin
            miscompares = miscompares + 1;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input memMode_e mode);
        memMode = mode;
        for (int a = 0; a < DEPTH; a++) memArray[a] = 16'($urandom);
        handshakes = 0;
        validRises = 0;
        protoErrs  = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            @(posedge clk); #1;
            n = n + 1;
        end
        checkOutput({tag, "_done"}, done, 1'b1);
    endtask

    task automatic checkResults(input string tag);
        int expErr, expFirst, badCells;
        logic expTimeout;
        refModel(expErr, expFirst, expTimeout);
        checkOutput({tag, "_err_cnt"}, errCnt, expErr);
        checkOutput({tag, "_first_err"}, firstErr, expFirst);
        checkOutput({tag, "_timeout"}, tmo, expTimeout);
        checkOutput({tag, "_pass"}, pass, (expErr == 0) && !expTimeout);
        checkOutput({tag, "_busy"}, busy, 1'b0);
        checkOutput({tag, "_protocol"}, protoErrs, 0);
        checkOutput({tag, "_handshakes"}, handshakes, expTimeout ? 0 : 4 * DEPTH);
        if (!expTimeout) begin
            badCells = 0;
            for (int a = 0; a < DEPTH; a++)
                if (memArray[a] !== ~(16'(a) ^ SEED)) badCells = badCells + 1;
            checkOutput({tag, "_mem_image"}, badCells, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired before the bench finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        faultAddr = 0;
        faultBit = 0;
        faultVal = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ctrl", {busy, done, pass, tmo, valid, wrRd}, '0);
        checkOutput("rst_err_cnt", errCnt, '0);
        checkOutput("rst_addr", {firstErr, addr}, '0);
        checkOutput("rst_wdata", wdata, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] scenario 1: good memory");
        applyStimulus(MEM_GOOD);
        checkOutput("s1_busy_after_start", busy, 1'b1);
        waitDone("s1", 2000, cycles);
        checkResults("s1");

        $display("[TB] scenario 2: addr 5 bit 0 stuck at 1");
        faultAddr = 5; faultBit = 0; faultVal = 1'b1;
        applyStimulus(MEM_STUCK);
        waitDone("s2", 2000, cycles);
        checkOutput("s2_err_one", errCnt, 1);
        checkOutput("s2_first_five", firstErr, 5);
        checkResults("s2");

        $display("[TB] scenario 3: read data always zero");
        applyStimulus(MEM_ZERO);
        waitDone("s3", 2000, cycles);
        checkOutput("s3_err_32", errCnt, 32);
        checkResults("s3");

        $display("[TB] scenario 6: restart clears results, mid-run start ignored");
        applyStimulus(MEM_GOOD);
        checkOutput("s6_err_cleared", errCnt, 0);
        checkOutput("s6_done_cleared", done, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("s6_busy_kept", busy, 1'b1);
        waitDone("s6", 2000, cycles);
        checkResults("s6");

        $display("[TB] scenario 4: ready never arrives");
        applyStimulus(MEM_NOREADY);
        waitDone("s4", 50, cycles);
        checkOutput("s4_within_10", (cycles + 1) <= 10, 1'b1);
        checkOutput("s4_valid_rises", validRises, 1);
        checkResults("s4");

        applyStimulus(MEM_GOOD);
        checkOutput("s4b_timeout_cleared", tmo, 1'b0);
        waitDone("s4b", 2000, cycles);
        checkResults("s4b");

        $display("[TB] scenario 5: reset in the middle of R0");
        applyStimulus(MEM_ZERO);
        cycles = 0;
        while (handshakes < DEPTH + 4 && cycles < 500) begin
            @(posedge clk); #1;
            cycles = cycles + 1;
        end
        checkOutput("s5_reached_r0", handshakes >= DEPTH + 4, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("s5_rst_ctrl", {busy, done, pass, tmo, valid, wrRd}, '0);
        checkOutput("s5_rst_err_cnt", errCnt, '0);
        checkOutput("s5_rst_addr", {firstErr, addr}, '0);
        checkOutput("s5_rst_wdata", wdata, '0);
        rst = 1'b0;
        @(posedge clk); #1;
        applyStimulus(MEM_GOOD);
        waitDone("s5", 2000, cycles);
        checkResults("s5");

        for (int k = 0; k < 3; k++) begin
            faultAddr = int'($urandom_range(DEPTH - 1, 0));
            faultBit  = int'($urandom_range(WIDTH - 1, 0));
            faultVal  = 1'($urandom_range(1, 0));
            $display("[TB] random stuck-at: addr %0d bit %0d value %0d", faultAddr, faultBit, faultVal);
            applyStimulus(MEM_STUCK);
            waitDone("rnd", 2000, cycles);
            checkResults("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
